// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match engine host driver.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int NUM_PAT = 4;
    localparam int TIMEOUT = 255;

    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DOT    = 8'h2E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRST,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_WAIT,
        ST_RESULT,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [1:0] pat_id;
        logic       match;
        logic [4:0] index;
        logic       timeout;
    } result_t;

    // Pattern lengths live in 1..PAT_MAX; a zero request still sends one byte.
    function automatic logic [3:0] clamp_pat_len(input logic [5:0] len);
        if (len == 6'd0) begin
            return 4'd1;
        end else if (len > 6'(PAT_MAX)) begin
            return 4'(PAT_MAX);
        end else begin
            return len[3:0];
        end
    endfunction

endpackage

// File: rtl/sme_cfg_buf.sv
// Subject string and pattern slot storage with length clamping.
// Writes land only while i_en is high (driver idle).
module sme_cfg_buf
    import sme_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_we,
    input  logic       i_len_we,
    input  logic [2:0] i_sel,
    input  logic [4:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_str_idx,
    output logic [7:0] o_str_byte,
    output logic [5:0] o_str_len,
    input  logic [1:0] i_pat_sel,
    input  logic [2:0] i_pat_idx,
    output logic [7:0] o_pat_byte,
    output logic [3:0] o_pat_len,
    input  logic [1:0] i_nx_sel,
    output logic [7:0] o_nx_first,
    output logic [3:0] o_nx_len
);

    logic [7:0] r_str [STR_MAX];
    logic [5:0] r_str_len;
    logic       w_str_hit;

    logic [7:0] w_pat_at    [NUM_PAT];
    logic [7:0] w_pat_first [NUM_PAT];
    logic [3:0] w_pat_len   [NUM_PAT];

    assign w_str_hit = i_en && (i_sel == 3'd0);

    always_ff @(posedge clk) begin
        if (w_str_hit && i_we) begin
            r_str[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_str_len <= 6'd0;
        end else if (w_str_hit && i_len_we) begin
            r_str_len <= (i_wdata[5:0] > 6'(STR_MAX)) ? 6'(STR_MAX) : i_wdata[5:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PAT; gi++) begin : g_slot
            logic [7:0] r_bytes [PAT_MAX];
            logic [3:0] r_len;
            logic       w_hit;

            assign w_hit = i_en && (i_sel == 3'(gi + 1));

            always_ff @(posedge clk) begin
                if (w_hit && i_we && (i_addr < 5'(PAT_MAX))) begin
                    r_bytes[i_addr[2:0]] <= i_wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_len <= 4'd0;
                end else if (w_hit && i_len_we) begin
                    r_len <= clamp_pat_len(i_wdata[5:0]);
                end
            end

            // An untouched slot (length 0 after reset) behaves as one byte.
            assign w_pat_at[gi]    = r_bytes[i_pat_idx];
            assign w_pat_first[gi] = r_bytes[0];
            assign w_pat_len[gi]   = (r_len == 4'd0) ? 4'd1 : r_len;
        end
    endgenerate

    assign o_str_byte = r_str[i_str_idx];
    assign o_str_len  = r_str_len;
    assign o_pat_byte = w_pat_at[i_pat_sel];
    assign o_pat_len  = w_pat_len[i_pat_sel];
    assign o_nx_first = w_pat_first[i_nx_sel];
    assign o_nx_len   = w_pat_len[i_nx_sel];

endmodule

// File: rtl/sme_host_driver.sv
// Host-side feeder for the string-match engine: resets it, streams string and patterns,
// forwards one result per pattern. Define SME_TIMEOUT_EN to add the WAIT watchdog.
module sme_host_driver
    import sme_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic       cfg_len_we,
    input  logic [2:0] cfg_sel,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic [2:0] cfg_npat,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       dut_rst,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       res_valid,
    output logic [1:0] res_pat_id,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout
);

    state_t     r_state;
    logic [4:0] r_idx;
    logic [1:0] r_pat;
    logic [2:0] r_npat;
    result_t    r_res;
    logic       r_busy;
    logic       r_done;
    logic       r_dut_rst;
    logic       r_res_valid;

    logic [7:0] w_str_byte;
    logic [5:0] w_str_len;
    logic [7:0] w_pat_byte;
    logic [3:0] w_pat_len;
    logic [7:0] w_nx_first;
    logic [3:0] w_nx_len;
    logic [1:0] w_nx_sel;
    logic       w_more;
    logic       w_str_last;
    logic       w_pat_last;
    logic       w_start_ok;
    logic       w_timeout;

    sme_cfg_buf u_cfg_buf (
        .clk        (clk),
        .reset      (reset),
        .i_en       (r_state == ST_IDLE),
        .i_we       (cfg_we),
        .i_len_we   (cfg_len_we),
        .i_sel      (cfg_sel),
        .i_addr     (cfg_addr),
        .i_wdata    (cfg_wdata),
        .i_str_idx  (r_idx),
        .o_str_byte (w_str_byte),
        .o_str_len  (w_str_len),
        .i_pat_sel  (r_pat),
        .i_pat_idx  (r_idx[2:0]),
        .o_pat_byte (w_pat_byte),
        .o_pat_len  (w_pat_len),
        .i_nx_sel   (w_nx_sel),
        .o_nx_first (w_nx_first),
        .o_nx_len   (w_nx_len)
    );

    assign w_nx_sel   = r_pat + 2'd1;
    assign w_more     = (({1'b0, r_pat}) + 3'd1) < r_npat;
    assign w_str_last = ({1'b0, r_idx} == (w_str_len - 6'd1));
    assign w_pat_last = (r_idx == ({1'b0, w_pat_len} - 5'd1));
    assign w_start_ok = start && (w_str_len != 6'd0) && (cfg_npat != 3'd0)
                        && (cfg_npat <= 3'(NUM_PAT));

`ifdef SME_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Counts WAIT cycles; zero in the first WAIT cycle of every wait.
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_WAIT)) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_timeout   = (r_cnt == 8'(TIMEOUT - 1));
    assign res_timeout = r_res.timeout;
`else
    assign w_timeout   = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 5'd0;
            r_pat       <= 2'd0;
            r_npat      <= 3'd0;
            r_res       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dut_rst   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_dut_rst   <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_DRST;
                        r_busy    <= 1'b1;
                        r_dut_rst <= 1'b1;
                        r_npat    <= cfg_npat;
                        r_pat     <= 2'd0;
                    end
                end
                ST_DRST: begin
                    r_state <= ST_SEND_STR;
                    r_idx   <= 5'd0;
                end
                ST_SEND_STR: begin
                    if (w_str_last) begin
                        r_state <= ST_SEND_PAT;
                        r_idx   <= 5'd0;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                ST_SEND_PAT: begin
                    if (w_pat_last) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                ST_WAIT: begin
                    if (valid) begin
                        r_res.pat_id  <= r_pat;
                        r_res.match   <= match;
                        r_res.index   <= match_index;
                        r_res.timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_RESULT;
                    end else if (w_timeout) begin
                        r_res.pat_id  <= r_pat;
                        r_res.match   <= 1'b0;
                        r_res.index   <= 5'd0;
                        r_res.timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    // Byte 0 of the next pattern already went out with valid.
                    if (!r_res.timeout && w_more) begin
                        r_pat <= w_nx_sel;
                        if (w_nx_len == 4'd1) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_SEND_PAT;
                            r_idx   <= 5'd1;
                        end
                    end else begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The byte lane is decoded from state so the WAIT handover can follow valid directly.
    always_comb begin
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
        case (r_state)
            ST_SEND_STR: begin
                chardata = w_str_byte;
                isstring = 1'b1;
            end
            ST_SEND_PAT: begin
                chardata  = w_pat_byte;
                ispattern = 1'b1;
            end
            ST_WAIT: begin
                if (w_more) begin
                    chardata  = w_nx_first;
                    ispattern = valid;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign dut_rst    = r_dut_rst;
    assign res_valid  = r_res_valid;
    assign res_pat_id = r_res.pat_id;
    assign res_match  = r_res.match;
    assign res_index  = r_res.index;

endmodule

// File: doc/sme_host_driver.md
Name: sme_host_driver

Overview:
- Initiator side of the string-match engine's serial byte protocol.
- Holds one subject string (≤32 chars) and up to NUM_PAT patterns (≤8 chars each), loaded through a config write port.
- On start: pulses a reset to the engine, streams the string with isstring, then each pattern with ispattern.
- Waits for the engine's valid after each pattern and forwards one result record per pattern.
- Used as the on-chip feeder and self-check harness for the matcher.

Parameters:
- STR_MAX, 32, max string bytes; length field width is 6 bits.
- PAT_MAX, 8, max pattern bytes.
- NUM_PAT, 4, pattern slots; pattern ids are 2 bits wide.
- TIMEOUT, 255, watchdog cycles in WAIT; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  write one buffer byte
- cfg_len_we  in  1  write the length of the selected buffer from cfg_wdata[5:0]
- cfg_sel  in  3  0 = string; 1..NUM_PAT = pattern slot (sel-1)
- cfg_addr  in  5  byte index
- cfg_wdata  in  8  write data
- cfg_npat  in  3  number of patterns to run (1..NUM_PAT), sampled at start
- start  in  1  run request, single-cycle pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- dut_rst  out  1  reset pulse to the engine
- chardata  out  8  byte to the engine
- isstring  out  1  string byte qualifier
- ispattern  out  1  pattern byte qualifier
- valid  in  1  engine result strobe
- match  in  1  engine match flag
- match_index  in  5  engine match position
- res_valid  out  1  one-cycle result strobe
- res_pat_id  out  2  pattern slot of the result
- res_match  out  1  captured match flag
- res_index  out  5  captured match position
- res_timeout  out  1  watchdog expiry flag

Behaviour:
- Reset: all outputs 0; FSM to IDLE; length registers 0. Buffer contents are not reset.
- Config writes:
  - Accepted only in IDLE (busy=0); ignored otherwise.
  - String length is clamped to 32; pattern length is clamped to 1..8 (0 is treated as 1).
  - Writes with cfg_sel > NUM_PAT are ignored.
- States: IDLE, DRST, SEND_STR, SEND_PAT, WAIT, RESULT, FIN.
- IDLE: start with str_len≠0 and cfg_npat in 1..NUM_PAT → DRST, busy=1. Otherwise start is ignored. Start while busy is ignored.
- DRST: dut_rst=1 for exactly one cycle → SEND_STR.
- SEND_STR:
  - isstring=1, chardata=str[i] for i = 0..str_len-1, one byte per cycle, with no gaps.
  - The last byte is followed in the very next cycle by SEND_PAT. There is no idle cycle between string and pattern.
- SEND_PAT:
  - ispattern=1, chardata=pat[p][j].
  - j starts at 0 for the first pattern. For later patterns j starts at 1, because byte 0 was already delivered in WAIT.
  - After the last byte → WAIT.
- WAIT:
  - isstring=ispattern=0.
  - chardata = pat[p+1][0] if another pattern remains, else 0.
  - When valid=1 and another pattern remains, ispattern is driven to 1 combinationally in that same cycle. This is the engine's one-cycle handover: the first byte of the next pattern coincides with valid.
  - On valid, capture match and match_index → RESULT.
- RESULT:
  - res_valid=1 for one cycle, res_pat_id=p, fields as captured.
  - Latency: res_valid follows valid by exactly 1 cycle.
  - Then p+1, and go to SEND_PAT (starting at j=1) if p+1 < npat, else FIN.
  - A single-byte next pattern goes from RESULT directly to WAIT, with ispattern low.
- FIN: done=1 for one cycle, busy=0 → IDLE.
- Engine resynchronisation: the engine cannot return to string mode without reset, so every run begins with DRST.
- valid outside WAIT: ignored.
- Reset mid-run: returns to IDLE in the next cycle; no done or res_valid is issued.

Optional Feature:
- SME_TIMEOUT_EN defined:
  - An 8-bit counter cleared on entry to WAIT.
  - If it reaches TIMEOUT with no valid: RESULT with res_timeout=1, res_match=0, res_index=0.
  - The remaining patterns are aborted → FIN.
- SME_TIMEOUT_EN undefined: WAIT is unbounded and res_timeout is tied to 0.

Decomposition:
- Package sme_pkg holds:
  - state enum;
  - STR_MAX, PAT_MAX and the byte constants (space 0x20, '^' 0x5E, '$' 0x24, '*' 0x2A, '.' 0x2E);
  - the result record struct {pat_id, match, index, timeout}.
- One natural sub-module: sme_cfg_buf, holding the string and pattern byte arrays, the length registers, the write decode and the clamping.

Test Plan:
- Load string "hello world" (len 11), pattern "wor" (len 3), npat=1, start:
  - dut_rst pulses on cycle 1;
  - isstring high for 11 cycles, then ispattern high for 3 cycles;
  - the bench engine model returns valid with match=1, index=6;
  - next cycle res_valid=1, res_pat_id=0, res_match=1, res_index=6; done one cycle later.
- npat=3 with patterns "ab", "c", "^x":
  - verify the first byte of patterns 1 and 2 is driven with ispattern=1 in the valid cycle;
  - verify 3 res_valid pulses, with ids 0, 1, 2.
- start with str_len=0, or with npat=0 → busy stays 0, no outputs toggle.
- Reset asserted in the middle of SEND_PAT → next cycle all outputs 0, FSM in IDLE; a subsequent start runs normally.
- With SME_TIMEOUT_EN: the model never asserts valid → after 255 WAIT cycles, res_valid with res_timeout=1; done follows and the remaining patterns are skipped.
- cfg_we during busy attempts to write str[0]="Z" → the buffer is unchanged, and the next run streams the original byte.
